// File: rtl/uart_fifo_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | uart_fifo_tx: drains a FIFO read port and sends 8N1 frames on the TX pin  |
// | (8E1 when UART_TX_PARITY_EN is defined).                       Rev 1.0    |
// +---------------------------------------------------------------------------+
module uart_fifo_tx #(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE       = 115_200,
    parameter int DATA_BITS       = 8
) (
    input  logic                 clk,
    input  logic                 nrst_in,
    input  logic                 empty_in,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 read_out,
    output logic                 tx_serial_out,
    output logic                 tx_busy_out,
    output logic                 tx_done_out
);

    localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_fifo_tx: CLOCK_FREQUENCY/BAUD_RATE must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_STOP   = 3'd5
`ifdef UART_TX_PARITY_EN
        ,
        S_PARITY = 3'd6
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif
    logic                  baud_end;

    assign baud_end      = (baud_q == BAUD_LAST);
    assign tx_serial_out = tx_q;
    assign tx_busy_out   = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        read_out    = 1'b0;
        tx_done_out = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!empty_in) state_d = S_FETCH;
            end
            S_FETCH: begin
                read_out = 1'b1;
                state_d  = S_LOAD;
            end
            S_LOAD: begin
                shift_d = data_in;
`ifdef UART_TX_PARITY_EN
                parity_d = ^data_in;
`endif
                baud_d  = '0;
                state_d = S_START;
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    baud_d      = '0;
                    tx_done_out = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line level follows the next state so the pin and tx_done_out stay cycle-aligned.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_uart_fifo_tx: directed bench for uart_fifo_tx at 16 clocks per bit.    |
// | Honours UART_TX_PARITY_EN.                                     Rev 1.0    |
// +---------------------------------------------------------------------------+
module tb_uart_fifo_tx;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_LEN = 11 * CPB;
`else
    localparam int FRAME_LEN = 10 * CPB;
`endif

    logic       clk = 1'b0;
    logic       nrst_in = 1'b1;
    logic       empty_in;
    logic [7:0] data_in;
    logic       read_out, tx_serial_out, tx_busy_out, tx_done_out;

    logic [7:0] fifo_mem [0:15];
    logic [3:0] wr_ptr = 4'd0;
    logic [3:0] rd_ptr = 4'd0;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int bad_rd = 0;

    bit cap_line [0:399];
    bit cap_done [0:399];
    bit cap_busy [0:399];

    uart_fifo_tx #(
        .CLOCK_FREQUENCY(1_600_000),
        .BAUD_RATE      (100_000),
        .DATA_BITS      (8)
    ) dut (
        .clk          (clk),
        .nrst_in      (nrst_in),
        .empty_in     (empty_in),
        .data_in      (data_in),
        .read_out     (read_out),
        .tx_serial_out(tx_serial_out),
        .tx_busy_out  (tx_busy_out),
        .tx_done_out  (tx_done_out)
    );

    always #5 clk = ~clk;

    // FIFO with one-cycle read latency
    assign empty_in = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (read_out) begin
            data_in <= fifo_mem[rd_ptr];
            rd_ptr  <= rd_ptr + 4'd1;
        end
    end

    always @(negedge clk) begin
        if (read_out) rd_cnt <= rd_cnt + 1;
        if (read_out && empty_in) bad_rd <= bad_rd + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic wait_start(output bit found);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (tx_serial_out === 1'b0) found = 1'b1;
        end
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            cap_line[i] = tx_serial_out;
            cap_done[i] = tx_done_out;
            cap_busy[i] = tx_busy_out;
        end
    endtask

    function automatic bit exp_line(input logic [7:0] b, input int c);
        if (c < CPB) return 1'b0;
        if (c < 9 * CPB) return b[(c - CPB) / CPB];
`ifdef UART_TX_PARITY_EN
        if (c < 10 * CPB) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic int line_mism(input logic [7:0] b, input int off);
        int m = 0;
        for (int c = 0; c < FRAME_LEN; c++)
            if (cap_line[off + c] != exp_line(b, c)) m++;
        return m;
    endfunction

    function automatic int decode(input int off);
        logic [7:0] d;
        for (int k = 0; k < 8; k++) d[k] = cap_line[off + CPB * (k + 1) + CPB / 2];
        return int'(d);
    endfunction

    function automatic int first_done(input int n);
        for (int i = 0; i < n; i++) if (cap_done[i]) return i;
        return -1;
    endfunction

    function automatic int count_done(input int n);
        int k = 0;
        for (int i = 0; i < n; i++) if (cap_done[i]) k++;
        return k;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   found;
        int   rd0, viol, lows, dones, highs, busy_lo;
        logic [7:0] pbytes [0:1];
        bit   pexp [0:1];

        // Reset values
        #2 nrst_in = 1'b0;
        #1;
        chk("rst_tx", tx_serial_out, 1);
        chk("rst_read", read_out, 0);
        chk("rst_busy", tx_busy_out, 0);
        chk("rst_done", tx_done_out, 0);
        repeat (3) @(negedge clk);
        nrst_in = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte 0xA5
        rd0 = rd_cnt;
        push(8'hA5);
        wait_start(found);
        chk("single_start", found, 1);
        capture(FRAME_LEN + 4);
        chk("single_line", line_mism(8'hA5, 0), 0);
        chk("single_data", decode(0), 8'hA5);
        chk("single_done_at", first_done(FRAME_LEN + 4), FRAME_LEN - 1);
        chk("single_done_cnt", count_done(FRAME_LEN + 4), 1);
        #2;
        chk("single_reads", rd_cnt - rd0, 1);

        // Back-to-back 0x00, 0xFF
        repeat (5) @(negedge clk);
        rd0 = rd_cnt;
        push(8'h00);
        push(8'hFF);
        wait_start(found);
        chk("b2b_start", found, 1);
        capture(2 * FRAME_LEN + 7);
        chk("b2b_line1", line_mism(8'h00, 0), 0);
        chk("b2b_line2", line_mism(8'hFF, FRAME_LEN + 3), 0);
        chk("b2b_data1", decode(0), 8'h00);
        chk("b2b_data2", decode(FRAME_LEN + 3), 8'hFF);
        highs = 0;
        busy_lo = 0;
        for (int i = FRAME_LEN; i < FRAME_LEN + 3; i++) begin
            if (cap_line[i]) highs++;
            if (!cap_busy[i]) busy_lo++;
        end
        chk("b2b_gap_high", highs, 3);
        chk("b2b_second_edge", cap_line[FRAME_LEN + 3], 0);
        chk("b2b_busy_low", busy_lo, 1);
        chk("b2b_dones", count_done(2 * FRAME_LEN + 7), 2);
        #2;
        chk("b2b_reads", rd_cnt - rd0, 2);

        // Empty hold
        repeat (5) @(negedge clk);
        rd0 = rd_cnt;
        viol = 0;
        repeat (1000) begin
            @(negedge clk);
            if (read_out !== 1'b0 || tx_serial_out !== 1'b1 || tx_busy_out !== 1'b0) viol++;
        end
        chk("empty_idle", viol, 0);
        #2;
        chk("empty_reads", rd_cnt - rd0, 0);

        // Reset during data bit 3 of 0x3C
        @(negedge clk);
        rd0 = rd_cnt;
        push(8'h3C);
        wait_start(found);
        chk("rstmid_start", found, 1);
        repeat (70) @(negedge clk);
        chk("rstmid_bit3", tx_serial_out, 1);
        nrst_in = 1'b0;
        #1;
        chk("rstmid_tx", tx_serial_out, 1);
        chk("rstmid_busy", tx_busy_out, 0);
        chk("rstmid_done", tx_done_out, 0);
        repeat (5) @(negedge clk);
        nrst_in = 1'b1;
        lows = 0;
        dones = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx_serial_out !== 1'b1) lows++;
            if (tx_done_out !== 1'b0) dones++;
        end
        chk("rstmid_no_frame", lows, 0);
        chk("rstmid_no_done", dones, 0);
        #2;
        chk("rstmid_reads", rd_cnt - rd0, 1);

        // Parity bytes; bit slot 152 is parity with the feature, stop otherwise
        pbytes[0] = 8'h07;
        pbytes[1] = 8'h03;
`ifdef UART_TX_PARITY_EN
        pexp[0] = 1'b1;
        pexp[1] = 1'b0;
`else
        pexp[0] = 1'b1;
        pexp[1] = 1'b1;
`endif
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            push(pbytes[p]);
            wait_start(found);
            chk("par_start", found, 1);
            capture(FRAME_LEN + 4);
            chk("par_line", line_mism(pbytes[p], 0), 0);
            chk("par_slot", cap_line[9 * CPB + CPB / 2], pexp[p]);
            chk("par_len", first_done(FRAME_LEN + 4) + 1, FRAME_LEN);
            repeat (4) @(negedge clk);
        end

        #2;
        chk("no_read_when_empty", bad_rd, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
